lcd_timing_gen: RTL and testbench
=================================

// Module: lcd_timing_gen
// PURPOSE
//  Downstream consumer of the PSRAM frame-fetch pixel stream. Generates 480x272 RGB-panel timing
//  (hsync/vsync/den), pulls one RGB565 pixel per active pclk over a valid/ready handshake and
//  drives registered panel signals. Underflows are detected and counted. Sits between the fetch
//  path and the top-level LCD output registers.
// PARAMETERS
//  H_SYNC   4    hsync width, pclk      | H_BP 43  h back porch | H_ACTIVE 480 | H_FP 8  h front porch
//  V_SYNC   4    vsync width, lines     | V_BP 12  v back porch | V_ACTIVE 272 | V_FP 8  v front porch
//  FILL_RGB 16'h0000  colour driven on underflow and outside the active region
// PORTS
//  clk            in   1   pixel clock, 10 MHz domain; all logic is posedge clk
//  reset_n        in   1   synchronous, active-low reset
//  enable         in   1   1 = run timing; 0 = hold idle
//  pix_data       in   16  RGB565 {r[4:0],g[5:0],b[4:0]} from fetch stage
//  pix_valid      in   1   pix_data valid
//  pix_ready      out  1   block accepts a pixel this cycle
//  frame_start    out  1   1-cycle pulse at hcnt=0,vcnt=0; upstream restarts its fetch
//  line_start     out  1   1-cycle pulse at hcnt=0, every line
//  lcd_r/g/b      out  5/6/5  registered pixel
//  lcd_hsync      out  1   registered, active-high (the top inverts it)
//  lcd_vsync      out  1   registered, active-high
//  lcd_den        out  1   registered data enable
//  underflow      out  1   sticky: set by any active pixel with no pix_valid
//  underflow_cnt  out  16  count of underflowed pixels, saturating at 16'hFFFF
//  clr_underflow  in   1   clears underflow and underflow_cnt
// BEHAVIOUR
//  - Counters: hcnt 0..H_TOTAL-1 (535 total), vcnt 0..V_TOTAL-1 (296 total). vcnt increments when
//    hcnt wraps; both wrap to 0. Line order is sync, back porch, active, front porch.
//  - hs_i = hcnt<H_SYNC; vs_i = vcnt<V_SYNC.
//  - act_i = hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) && vcnt in [V_SYNC+V_BP, +V_ACTIVE).
//  - pix_ready = act_i, combinational from counters. A transfer occurs on pix_valid & pix_ready.
//  - Output stage, one register stage; all outputs stay mutually aligned:
//    - lcd_hsync<=hs_i, lcd_vsync<=vs_i, lcd_den<=act_i.
//    - rgb<=pix_data on transfer, otherwise FILL_RGB.
//    - Latency from counter state to pins is 1 clk.
//  - Underflow: act_i & ~pix_valid sets underflow and increments underflow_cnt (saturating).
//    clr_underflow in the same cycle as an increment: clear wins, so the count is 0.
//  - frame_start/line_start are combinational from counters, gated by enable.
//  - enable=0: hcnt=vcnt=0 held; pix_ready=0; no pulses; registered outputs go to 0 next clk.
//    - enable 0->1: the first cycle has hcnt=0,vcnt=0 and frame_start=1. A frame always starts clean.
//    - enable dropped mid-frame: counters return to 0 immediately; no partial-frame resume.
//  - pix_valid outside act_i: ignored, nothing consumed, no error.
//  - Reset (reset_n=0 at a posedge): counters 0; all outputs 0 (lcd_* , pulses, underflow,
//    underflow_cnt). Reset mid-frame behaves the same as reset at idle.
// CONFIGURATION
//  LCD_TEST_PATTERN_EN defined:
//    - Adds input test_mode(1). When test_mode=1, the active-region pixel is an 8-bar colour
//      pattern, bar = (hcnt-(H_SYNC+H_BP))/60, colours white,yellow,cyan,green,magenta,red,blue,black.
//    - In test mode pix_ready=0 and underflow is not counted.
//  Macro undefined: no test_mode port; the pixel source is always pix_data.
// STRUCTURE
//  Package lcd_pkg:
//    - Default timing localparams (H_*/V_*, H_TOTAL, V_TOTAL).
//    - typedef rgb565_t (packed struct r/g/b).
//    - Test-bar colour constants.
//  Sub-module lcd_sync_counter: hcnt/vcnt counters with enable, wrap and hs_i/vs_i/act_i decode.
//  The top of this block holds the handshake, underflow logic and output registers.
// TESTING
//  1 Reset then enable=1, pix_valid=1 held:
//    - lcd_hsync high 4 clk of every 535; lcd_vsync high 4 lines of 296.
//    - Exactly 480x272 = 130560 den cycles per frame.
//  2 Ramp source (pix_data=index):
//    - Pixel n appears on the pins 1 clk after its transfer.
//    - The first den pixel of a frame is 0; the last is 130559 (mod 2^16).
//  3 pix_valid=0 for 10 active cycles mid-line:
//    - rgb=FILL_RGB on those cycles, underflow=1, underflow_cnt=10.
//    - clr_underflow coincident with an 11th miss gives cnt=0.
//  4 Drop enable at hcnt=200, line 100; re-enable 5 clk later:
//    - pins 0 within 1 clk; frame_start pulses on the re-enable cycle.
//    - The next hsync rises 1 clk after that.
//  5 Assert reset_n=0 mid-active for 1 clk:
//    - all outputs 0; counters restart at 0.
//    - underflow_cnt reads 0 afterwards.
//  6 With LCD_TEST_PATTERN_EN, test_mode=1:
//    - active pixels at offsets 0,60,...,420 read FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
//    - pix_ready stays 0 throughout.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared timing constants, pixel type and colour-bar palette for the 480x272 LCD timing path.
// LCD_TEST_PATTERN_EN selects whether the colour-bar generator is built.
package lcd_pkg;

    localparam int unsigned H_SYNC   = 4;
    localparam int unsigned H_BP     = 43;
    localparam int unsigned H_ACTIVE = 480;
    localparam int unsigned H_FP     = 8;
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BP     = 12;
    localparam int unsigned V_ACTIVE = 272;
    localparam int unsigned V_FP     = 8;
    localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;

    typedef logic [9:0] hcnt_t;
    typedef logic [8:0] vcnt_t;

    localparam hcnt_t H_SYNC_END  = hcnt_t'(H_SYNC);
    localparam hcnt_t H_ACT_START = hcnt_t'(H_SYNC + H_BP);
    localparam hcnt_t H_ACT_END   = hcnt_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam hcnt_t H_LAST      = hcnt_t'(H_TOTAL - 1);
    localparam hcnt_t BAR_WIDTH   = hcnt_t'(BAR_W);
    localparam vcnt_t V_SYNC_END  = vcnt_t'(V_SYNC);
    localparam vcnt_t V_ACT_START = vcnt_t'(V_SYNC + V_BP);
    localparam vcnt_t V_ACT_END   = vcnt_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam vcnt_t V_LAST      = vcnt_t'(V_TOTAL - 1);

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam rgb565_t FILL_RGB    = 16'h0000;
    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    function automatic rgb565_t bar_colour(logic [2:0] idx);
        rgb565_t c;
        unique case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            3'd7: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Pixel stream handshake between the frame-fetch stage (master) and the LCD timing block (slave).
interface lcd_timing_gen_if;
    import lcd_pkg::*;

    rgb565_t pix_data;
    logic    pix_valid;
    logic    pix_ready;
    logic    frame_start;
    logic    line_start;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        input  frame_start,
        input  line_start
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        output frame_start,
        output line_start
    );

endinterface

// File: rtl/lcd_sync_counter.sv
// Horizontal/vertical pixel counters with sync, active-region and line/frame pulse decode.
// With LCD_TEST_PATTERN_EN it also exports the colour-bar index of the current column.
module lcd_sync_counter
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_i,
`ifdef LCD_TEST_PATTERN_EN
    output logic [2:0] bar_o,
`endif
    output logic       hs_o,
    output logic       vs_o,
    output logic       act_o,
    output logic       frame_start_o,
    output logic       line_start_o
);

    hcnt_t hcnt_q, hcnt_d;
    vcnt_t vcnt_q, vcnt_d;

    // Disabled means parked at the origin, so a re-enable always begins a clean frame.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!enable_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + vcnt_t'(1);
        end else begin
            hcnt_d = hcnt_q + hcnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_comb begin
        hs_o          = enable_i && (hcnt_q < H_SYNC_END);
        vs_o          = enable_i && (vcnt_q < V_SYNC_END);
        act_o         = enable_i && (hcnt_q >= H_ACT_START) && (hcnt_q < H_ACT_END) &&
                        (vcnt_q >= V_ACT_START) && (vcnt_q < V_ACT_END);
        frame_start_o = enable_i && (hcnt_q == '0) && (vcnt_q == '0);
        line_start_o  = enable_i && (hcnt_q == '0);
    end

`ifdef LCD_TEST_PATTERN_EN
    hcnt_t x_off;

    always_comb begin
        x_off = hcnt_q - H_ACT_START;
        bar_o = 3'(x_off / BAR_WIDTH);
    end
`endif

endmodule

// File: rtl/lcd_timing_gen.sv
// 480x272 RGB-panel timing generator: pulls pixels over a valid/ready stream, tracks underflow,
// and drives registered panel pins. LCD_TEST_PATTERN_EN adds a test_mode colour-bar source.
module lcd_timing_gen
    import lcd_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable_i,
`ifdef LCD_TEST_PATTERN_EN
    input  logic                    test_mode_i,
`endif
    input  logic                    clr_underflow_i,
    lcd_timing_gen_if.slave         pix_if,
    output logic [4:0]              lcd_r_o,
    output logic [5:0]              lcd_g_o,
    output logic [4:0]              lcd_b_o,
    output logic                    lcd_hsync_o,
    output logic                    lcd_vsync_o,
    output logic                    lcd_den_o,
    output logic                    underflow_o,
    output logic [15:0]             underflow_cnt_o
);

    logic    run;
    logic    hs, vs, act, fs, ls;
    logic    test_active;
    rgb565_t pattern;
    logic    xfer, miss;

    // Holding reset also silences the combinational decode, not just the registers.
    assign run = enable_i & reset_n;

`ifdef LCD_TEST_PATTERN_EN
    logic [2:0] bar;
`endif

    lcd_sync_counter u_sync_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable_i      (run),
`ifdef LCD_TEST_PATTERN_EN
        .bar_o         (bar),
`endif
        .hs_o          (hs),
        .vs_o          (vs),
        .act_o         (act),
        .frame_start_o (fs),
        .line_start_o  (ls)
    );

`ifdef LCD_TEST_PATTERN_EN
    assign test_active = test_mode_i;
    assign pattern     = bar_colour(bar);
`else
    assign test_active = 1'b0;
    assign pattern     = FILL_RGB;
`endif

    assign pix_if.pix_ready   = act & ~test_active;
    assign pix_if.frame_start = fs;
    assign pix_if.line_start  = ls;

    assign xfer = pix_if.pix_valid & pix_if.pix_ready;
    assign miss = act & ~test_active & ~pix_if.pix_valid;

    rgb565_t     rgb_q, rgb_d;
    logic        hsync_q, vsync_q, den_q;
    logic        underflow_q, underflow_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        rgb_d       = FILL_RGB;
        underflow_d = underflow_q;
        cnt_d       = cnt_q;
        if (xfer) begin
            rgb_d = pix_if.pix_data;
        end else if (act && test_active) begin
            rgb_d = pattern;
        end
        if (miss) begin
            underflow_d = 1'b1;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        // A clear coincident with a miss must leave the count at zero.
        if (clr_underflow_i) begin
            underflow_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb_q       <= FILL_RGB;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            den_q       <= 1'b0;
            underflow_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rgb_q       <= rgb_d;
            hsync_q     <= hs;
            vsync_q     <= vs;
            den_q       <= act;
            underflow_q <= underflow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign lcd_r_o         = rgb_q.r;
    assign lcd_g_o         = rgb_q.g;
    assign lcd_b_o         = rgb_q.b;
    assign lcd_hsync_o     = hsync_q;
    assign lcd_vsync_o     = vsync_q;
    assign lcd_den_o       = den_q;
    assign underflow_o     = underflow_q;
    assign underflow_cnt_o = cnt_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: sync/den timing, pixel ramp, underflow, enable drop, reset.
module tb_lcd_timing_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clr = 1'b0;
`ifdef LCD_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic        lcd_hsync, lcd_vsync, lcd_den, underflow;
    logic [15:0] cnt;
    logic [15:0] rgb;

    int checks = 0;
    int errors = 0;
    int h = 0;
    int v = 0;

    assign rgb = {lcd_r, lcd_g, lcd_b};

    lcd_timing_gen_if pix_if ();

    lcd_timing_gen dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable_i        (enable),
`ifdef LCD_TEST_PATTERN_EN
        .test_mode_i     (test_mode),
`endif
        .clr_underflow_i (clr),
        .pix_if          (pix_if),
        .lcd_r_o         (lcd_r),
        .lcd_g_o         (lcd_g),
        .lcd_b_o         (lcd_b),
        .lcd_hsync_o     (lcd_hsync),
        .lcd_vsync_o     (lcd_vsync),
        .lcd_den_o       (lcd_den),
        .underflow_o     (underflow),
        .underflow_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    // Reference counter position, advanced at every posedge from the inputs seen there.
    task automatic tick();
        @(posedge clk);
        if (!reset_n || !enable) begin
            h = 0;
            v = 0;
        end else if (h == 534) begin
            h = 0;
            v = (v == 295) ? 0 : v + 1;
        end else begin
            h++;
        end
        #1;
    endtask

    function automatic logic act(int hh, int vv);
        return (hh >= 47) && (hh < 527) && (vv >= 16) && (vv < 288);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = 16'h0;
        tick();
        tick();
        checks++;
        if ({lcd_hsync, lcd_vsync, lcd_den, rgb} !== 19'h0) begin
            errors++;
            $display("FAIL reset_pins: got %h expected 0", {lcd_hsync, lcd_vsync, lcd_den, rgb});
        end
        checks++;
        if ({underflow, cnt} !== 17'h0) begin
            errors++;
            $display("FAIL reset_underflow: got %b/%0d expected 0/0", underflow, cnt);
        end
        checks++;
        if ({pix_if.pix_ready, pix_if.frame_start, pix_if.line_start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_comb: got %b expected 000",
                     {pix_if.pix_ready, pix_if.frame_start, pix_if.line_start});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({pix_if.frame_start, lcd_hsync} !== 2'b00) begin
            errors++;
            $display("FAIL idle_disabled: got %b expected 00", {pix_if.frame_start, lcd_hsync});
        end
    endtask

    task automatic test_frame_timing();
        int hs_n = 0;
        int vs_n = 0;
        int den_n = 0;
        int bad = 0;
        int idx = 0;
        int first_pix = -1;
        int last_pix = -1;
        logic exp_hs, exp_vs, exp_act;
        logic [15:0] exp_rgb;
        enable = 1'b1;
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = 16'h0;
        #1;
        checks++;
        if ({pix_if.frame_start, pix_if.line_start, pix_if.pix_ready} !== 3'b110) begin
            errors++;
            $display("FAIL enable_first_cycle: got %b expected 110",
                     {pix_if.frame_start, pix_if.line_start, pix_if.pix_ready});
        end
        for (int i = 0; i < 17 * 535; i++) begin
            exp_hs  = (h < 4);
            exp_vs  = (v < 4);
            exp_act = act(h, v);
            exp_rgb = exp_act ? 16'(idx) : 16'h0;
            pix_if.pix_data = 16'(idx);
            tick();
            if (exp_act) idx++;
            hs_n  += int'(lcd_hsync);
            vs_n  += int'(lcd_vsync);
            den_n += int'(lcd_den);
            if (lcd_den === 1'b1) begin
                if (first_pix < 0) first_pix = int'(rgb);
                last_pix = int'(rgb);
            end
            if (lcd_hsync !== exp_hs || lcd_vsync !== exp_vs || lcd_den !== exp_act ||
                rgb !== exp_rgb || pix_if.pix_ready !== act(h, v) ||
                pix_if.line_start !== (h == 0) || pix_if.frame_start !== (h == 0 && v == 0))
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL timing_per_cycle: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (hs_n !== 68) begin
            errors++;
            $display("FAIL hsync_width: got %0d high cycles expected 68", hs_n);
        end
        checks++;
        if (vs_n !== 2140) begin
            errors++;
            $display("FAIL vsync_width: got %0d high cycles expected 2140", vs_n);
        end
        checks++;
        if (den_n !== 480) begin
            errors++;
            $display("FAIL den_per_line: got %0d expected 480", den_n);
        end
        checks++;
        if (first_pix !== 0 || last_pix !== 479) begin
            errors++;
            $display("FAIL ramp_ends: got %0d..%0d expected 0..479", first_pix, last_pix);
        end
    endtask

    task automatic test_underflow();
        int bad = 0;
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = 16'h1234;
        while (h != 100) tick();
        checks++;
        if ({underflow, cnt} !== 17'h0) begin
            errors++;
            $display("FAIL underflow_before: got %b/%0d expected 0/0", underflow, cnt);
        end
        pix_if.pix_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rgb !== 16'h0000 || lcd_den !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL underflow_fill: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (underflow !== 1'b1 || cnt !== 16'd10) begin
            errors++;
            $display("FAIL underflow_count: got %b/%0d expected 1/10", underflow, cnt);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (underflow !== 1'b0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL clear_wins: got %b/%0d expected 0/0", underflow, cnt);
        end
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = 16'hBEEF;
        tick();
        checks++;
        if (rgb !== 16'hBEEF || cnt !== 16'd0) begin
            errors++;
            $display("FAIL recover_pixel: got %h/%0d expected beef/0", rgb, cnt);
        end
        while (h != 528) tick();
        pix_if.pix_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        pix_if.pix_valid = 1'b1;
        checks++;
        if (underflow !== 1'b0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL blank_no_underflow: got %b/%0d expected 0/0", underflow, cnt);
        end
    endtask

    task automatic test_enable_drop();
        int bad = 0;
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = 16'h5A5A;
        while (!(v == 100 && h == 200)) tick();
        checks++;
        if (lcd_den !== 1'b1 || rgb !== 16'h5A5A) begin
            errors++;
            $display("FAIL pre_drop_active: got %b/%h expected 1/5a5a", lcd_den, rgb);
        end
        enable = 1'b0;
        #1;
        checks++;
        if ({pix_if.pix_ready, pix_if.line_start, pix_if.frame_start} !== 3'b000) begin
            errors++;
            $display("FAIL drop_comb: got %b expected 000",
                     {pix_if.pix_ready, pix_if.line_start, pix_if.frame_start});
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            if ({lcd_hsync, lcd_vsync, lcd_den, rgb} !== 19'h0 || pix_if.frame_start !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL drop_pins_zero: got %0d bad cycles expected 0", bad);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (pix_if.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reenable_frame_start: got %b expected 1", pix_if.frame_start);
        end
        tick();
        checks++;
        if ({lcd_hsync, lcd_vsync, lcd_den} !== 3'b110) begin
            errors++;
            $display("FAIL reenable_hsync: got %b expected 110", {lcd_hsync, lcd_vsync, lcd_den});
        end
    endtask

    task automatic test_reset_mid();
        pix_if.pix_valid = 1'b1;
        while (!(v == 16 && h == 60)) tick();
        pix_if.pix_valid = 1'b0;
        tick();
        tick();
        tick();
        pix_if.pix_valid = 1'b1;
        checks++;
        if (cnt !== 16'd3) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d expected 3", cnt);
        end
        while (h != 100) tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({lcd_hsync, lcd_vsync, lcd_den, rgb, underflow, cnt} !== 36'h0) begin
            errors++;
            $display("FAIL mid_reset_regs: got %h expected 0",
                     {lcd_hsync, lcd_vsync, lcd_den, rgb, underflow, cnt});
        end
        checks++;
        if ({pix_if.pix_ready, pix_if.frame_start, pix_if.line_start} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_comb: got %b expected 000",
                     {pix_if.pix_ready, pix_if.frame_start, pix_if.line_start});
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (pix_if.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_at_origin: got %b expected 1", pix_if.frame_start);
        end
        tick();
        checks++;
        if ({lcd_hsync, lcd_vsync, lcd_den} !== 3'b110 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL restart_pins: got %b/%0d expected 110/0",
                     {lcd_hsync, lcd_vsync, lcd_den}, cnt);
        end
    endtask

`ifdef LCD_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [15:0] bars [8];
        int bad = 0;
        int off;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        test_mode = 1'b1;
        pix_if.pix_valid = 1'b0;
        while (!(v == 16 && h == 47)) tick();
        for (int k = 0; k < 480; k++) begin
            if (pix_if.pix_ready !== 1'b0) bad++;
            off = h - 47;
            tick();
            if (off % 60 == 0) begin
                checks++;
                if (rgb !== bars[off / 60]) begin
                    errors++;
                    $display("FAIL bar_%0d: got %h expected %h", off / 60, rgb, bars[off / 60]);
                end
            end
        end
        checks++;
        if (bad !== 0 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL test_mode_ready: got %0d ready cycles cnt %0d expected 0/0", bad, cnt);
        end
        test_mode = 1'b0;
        pix_if.pix_valid = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_frame_timing();
        test_underflow();
        test_enable_drop();
        test_reset_mid();
`ifdef LCD_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
